x87_cmd_pipe: RTL and testbench

X87_CMD_PIPE -- requirements
Module: x87_cmd_pipe

---
 rtl/x87_cmd_pipe_if.sv | 59 +++++
 rtl/x87_cmd_pipe.sv | 143 ++++++++++++++
 tb/tb_x87_cmd_pipe.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/x87_cmd_pipe_if.sv
// Command/exec/result bus of the x87 command pipe.
// The slave modport is the pipe's view; the master modport is the front-end/exec side.
interface x87_cmd_pipe_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MEM_W = 64,
  parameter int unsigned WB_W  = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_op1;
  logic [7:0]       req_op2;
  logic             req_op2_valid;
  logic [3:0]       req_step;
  logic [MEM_W-1:0] req_mem_rdata;
  logic             flush;

  logic             ex_start;
  logic [7:0]       ex_op1;
  logic [7:0]       ex_op2;
  logic             ex_op2_valid;
  logic [3:0]       ex_step;
  logic [MEM_W-1:0] ex_mem_rdata;
  logic             ex_done;
  logic             ex_wb_valid;
  logic [2:0]       ex_wb_kind;
  logic [WB_W-1:0]  ex_wb_value;
  logic             ex_ms_valid;
  logic [1:0]       ex_ms_size;
  logic [MEM_W-1:0] ex_ms_data;

  logic             fpu_busy;
  logic             fpu_done;
  logic             fpu_wb_valid;
  logic [2:0]       fpu_wb_kind;
  logic [WB_W-1:0]  fpu_wb_value;
  logic             memstore_valid;
  logic [1:0]       memstore_size;
  logic [MEM_W-1:0] memstore_data;
  logic [CNT_W-1:0] q_count;
  logic             err_timeout;

  modport master (
    output req_valid, req_op1, req_op2, req_op2_valid, req_step, req_mem_rdata, flush,
           ex_done, ex_wb_valid, ex_wb_kind, ex_wb_value, ex_ms_valid, ex_ms_size, ex_ms_data,
    input  req_ready, ex_start, ex_op1, ex_op2, ex_op2_valid, ex_step, ex_mem_rdata,
           fpu_busy, fpu_done, fpu_wb_valid, fpu_wb_kind, fpu_wb_value,
           memstore_valid, memstore_size, memstore_data, q_count, err_timeout
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_op2_valid, req_step, req_mem_rdata, flush,
           ex_done, ex_wb_valid, ex_wb_kind, ex_wb_value, ex_ms_valid, ex_ms_size, ex_ms_data,
    output req_ready, ex_start, ex_op1, ex_op2, ex_op2_valid, ex_step, ex_mem_rdata,
           fpu_busy, fpu_done, fpu_wb_valid, fpu_wb_kind, fpu_wb_value,
           memstore_valid, memstore_size, memstore_data, q_count, err_timeout
  );
endinterface

// File: rtl/x87_cmd_pipe.sv
// x87 command pipe: FIFO of decoded commands, one-at-a-time issue to the exec engine,
// registered completion/writeback with a WAIT-state timeout.
module x87_cmd_pipe #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MEM_W   = 64,
  parameter int unsigned WB_W    = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  x87_cmd_pipe_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned TMO_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [7:0]       op1;
    logic [7:0]       op2;
    logic             op2_valid;
    logic [3:0]       step;
    logic [MEM_W-1:0] mem_rdata;
  } entry_t;

  state_t           state_q;
  entry_t           mem_q [DEPTH];
  entry_t           head;
  entry_t           ex_q;
  logic             ex_start_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [TMO_W-1:0] wait_cnt_q;
  logic             fpu_done_q, fpu_wb_valid_q, memstore_valid_q, err_timeout_q;
  logic [2:0]       fpu_wb_kind_q;
  logic [WB_W-1:0]  fpu_wb_value_q;
  logic [1:0]       memstore_size_q;
  logic [MEM_W-1:0] memstore_data_q;
  logic             req_ready;
  logic             push, pop;

  assign req_ready = !rst && (count_q < CNT_W'(DEPTH)) && !bus.flush;
  assign push      = bus.req_valid && req_ready;
  assign pop       = (state_q == ISSUE);
  assign head      = mem_q[rd_ptr_q];

  // Queue storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{op1: bus.req_op1, op2: bus.req_op2, op2_valid: bus.req_op2_valid,
                           step: bus.req_step, mem_rdata: bus.req_mem_rdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      ex_q             <= '0;
      ex_start_q       <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      wait_cnt_q       <= '0;
      fpu_done_q       <= 1'b0;
      fpu_wb_valid_q   <= 1'b0;
      memstore_valid_q <= 1'b0;
      err_timeout_q    <= 1'b0;
      fpu_wb_kind_q    <= '0;
      fpu_wb_value_q   <= '0;
      memstore_size_q  <= '0;
      memstore_data_q  <= '0;
    end else begin
      fpu_done_q       <= 1'b0;
      fpu_wb_valid_q   <= 1'b0;
      memstore_valid_q <= 1'b0;
      ex_start_q       <= 1'b0;
      ex_q             <= '0;

      // Flush drops every queued entry; the head being issued this cycle still goes out.
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end

      case (state_q)
        IDLE: begin
          if (count_q != '0 && !bus.flush) begin
            state_q    <= ISSUE;
            ex_start_q <= 1'b1;
            ex_q       <= head;
          end
        end
        ISSUE: begin
          state_q    <= WAIT;
          wait_cnt_q <= '0;
        end
        WAIT: begin
          if (bus.ex_done) begin
            state_q          <= IDLE;
            fpu_done_q       <= 1'b1;
            fpu_wb_valid_q   <= bus.ex_wb_valid;
            fpu_wb_kind_q    <= bus.ex_wb_kind;
            fpu_wb_value_q   <= bus.ex_wb_value;
            memstore_valid_q <= bus.ex_ms_valid;
            memstore_size_q  <= bus.ex_ms_size;
            memstore_data_q  <= bus.ex_ms_data;
          end else if (wait_cnt_q == TMO_W'(TIMEOUT - 1)) begin
            state_q       <= IDLE;
            fpu_done_q    <= 1'b1;
            err_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + TMO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.ex_start       = ex_start_q;
  assign bus.ex_op1         = ex_q.op1;
  assign bus.ex_op2         = ex_q.op2;
  assign bus.ex_op2_valid   = ex_q.op2_valid;
  assign bus.ex_step        = ex_q.step;
  assign bus.ex_mem_rdata   = ex_q.mem_rdata;
  assign bus.fpu_busy       = (state_q != IDLE) || (count_q != '0);
  assign bus.fpu_done       = fpu_done_q;
  assign bus.fpu_wb_valid   = fpu_wb_valid_q;
  assign bus.fpu_wb_kind    = fpu_wb_kind_q;
  assign bus.fpu_wb_value   = fpu_wb_value_q;
  assign bus.memstore_valid = memstore_valid_q;
  assign bus.memstore_size  = memstore_size_q;
  assign bus.memstore_data  = memstore_data_q;
  assign bus.q_count        = count_q;
  assign bus.err_timeout    = err_timeout_q;
endmodule

// File: tb/tb_x87_cmd_pipe.sv
// Directed bench for x87_cmd_pipe: table of single-command transactions plus
// hand sequences for queue-full/wrap, flush, timeout and mid-WAIT reset.
module tb_x87_cmd_pipe;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MEM_W = 64;
  localparam int unsigned WB_W  = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  x87_cmd_pipe_if #(.DEPTH(DEPTH), .MEM_W(MEM_W), .WB_W(WB_W)) bus ();

  x87_cmd_pipe #(.DEPTH(DEPTH), .MEM_W(MEM_W), .WB_W(WB_W), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic        op2v;
    logic [3:0]  step;
    logic [63:0] mem;
    int          delay;
    logic        wbv;
    logic [2:0]  kind;
    logic [15:0] val;
    logic        msv;
    logic [1:0]  size;
    logic [63:0] data;
    logic [7:0]  e_op1;
    logic [7:0]  e_op2;
    logic        e_op2v;
    logic [3:0]  e_step;
    logic [63:0] e_mem;
    logic        e_wbv;
    logic [2:0]  e_kind;
    logic [15:0] e_val;
    logic        e_msv;
    logic [1:0]  e_size;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] o1, input logic [7:0] o2, input logic v2,
                       input logic [3:0] st, input logic [63:0] md);
    bus.req_valid     = 1'b1;
    bus.req_op1       = o1;
    bus.req_op2       = o2;
    bus.req_op2_valid = v2;
    bus.req_step      = st;
    bus.req_mem_rdata = md;
  endtask

  task automatic wait_start(input int bound, output int n);
    n = 0;
    while (bus.ex_start !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic set_done(input logic d, input logic wbv, input logic [2:0] kind,
                          input logic [15:0] val, input logic msv, input logic [1:0] size,
                          input logic [63:0] data);
    bus.ex_done     = d;
    bus.ex_wb_valid = wbv;
    bus.ex_wb_kind  = kind;
    bus.ex_wb_value = val;
    bus.ex_ms_valid = msv;
    bus.ex_ms_size  = size;
    bus.ex_ms_data  = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int starts;
    int dones;
    n_vec = 0;
    n_bad = 0;

    vecs[0] = '{8'hD9, 8'hE8, 1'b1, 4'd0, 64'h0, 2,
                1'b1, 3'd1, 16'h3F80, 1'b0, 2'd0, 64'h0,
                8'hD9, 8'hE8, 1'b1, 4'd0, 64'h0,
                1'b1, 3'd1, 16'h3F80, 1'b0, 2'd0, 64'h0};
    vecs[1] = '{8'hDD, 8'h00, 1'b0, 4'd3, 64'h400921FB54442D18, 1,
                1'b0, 3'd0, 16'h0000, 1'b1, 2'd2, 64'h400921FB54442D18,
                8'hDD, 8'h00, 1'b0, 4'd3, 64'h400921FB54442D18,
                1'b0, 3'd0, 16'h0000, 1'b1, 2'd2, 64'h400921FB54442D18};
    vecs[2] = '{8'hD8, 8'hC1, 1'b1, 4'd7, 64'h123456789ABCDEF0, 3,
                1'b1, 3'd5, 16'hA5A5, 1'b1, 2'd1, 64'h00000000DEADBEEF,
                8'hD8, 8'hC1, 1'b1, 4'd7, 64'h123456789ABCDEF0,
                1'b1, 3'd5, 16'hA5A5, 1'b1, 2'd1, 64'h00000000DEADBEEF};
    vecs[3] = '{8'hDE, 8'hF9, 1'b1, 4'd15, 64'hFFFFFFFFFFFFFFFF, 8,
                1'b1, 3'd7, 16'hFFFF, 1'b0, 2'd3, 64'h0123456789ABCDEF,
                8'hDE, 8'hF9, 1'b1, 4'd15, 64'hFFFFFFFFFFFFFFFF,
                1'b1, 3'd7, 16'hFFFF, 1'b0, 2'd3, 64'h0123456789ABCDEF};

    // Reset state
    rst = 1'b1;
    bus.flush = 1'b0;
    offer(8'h0, 8'h0, 1'b0, 4'h0, 64'h0);
    bus.req_valid = 1'b0;
    set_done(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 2'd0, 64'h0);
    #1;
    chk("rst_q_count", 64'(bus.q_count), 64'd0);
    chk("rst_busy", 64'(bus.fpu_busy), 64'd0);
    chk("rst_ex_start", 64'(bus.ex_start), 64'd0);
    chk("rst_fpu_done", 64'(bus.fpu_done), 64'd0);
    chk("rst_err", 64'(bus.err_timeout), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_ready", 64'(bus.req_ready), 64'd1);
    tick();

    // Single-command transactions
    for (int i = 0; i < 4; i++) begin
      offer(vecs[i].op1, vecs[i].op2, vecs[i].op2v, vecs[i].step, vecs[i].mem);
      #1 chk($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'd1);
      tick();
      bus.req_valid = 1'b0;
      chk($sformatf("v%0d_qcount", i), 64'(bus.q_count), 64'd1);
      chk($sformatf("v%0d_idle_start", i), 64'(bus.ex_start), 64'd0);
      wait_start(4, n);
      chk($sformatf("v%0d_latency", i), 64'(n), 64'd1);
      chk($sformatf("v%0d_ex_op1", i), 64'(bus.ex_op1), 64'(vecs[i].e_op1));
      chk($sformatf("v%0d_ex_op2", i), 64'(bus.ex_op2), 64'(vecs[i].e_op2));
      chk($sformatf("v%0d_ex_op2v", i), 64'(bus.ex_op2_valid), 64'(vecs[i].e_op2v));
      chk($sformatf("v%0d_ex_step", i), 64'(bus.ex_step), 64'(vecs[i].e_step));
      chk($sformatf("v%0d_ex_mem", i), bus.ex_mem_rdata, vecs[i].e_mem);
      repeat (vecs[i].delay) tick();
      chk($sformatf("v%0d_wait_nodone", i), 64'(bus.fpu_done), 64'd0);
      chk($sformatf("v%0d_wait_exop", i), 64'(bus.ex_op1), 64'd0);
      set_done(1'b1, vecs[i].wbv, vecs[i].kind, vecs[i].val, vecs[i].msv, vecs[i].size, vecs[i].data);
      tick();
      set_done(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 2'd0, 64'h0);
      chk($sformatf("v%0d_fpu_done", i), 64'(bus.fpu_done), 64'd1);
      chk($sformatf("v%0d_wb_valid", i), 64'(bus.fpu_wb_valid), 64'(vecs[i].e_wbv));
      chk($sformatf("v%0d_wb_kind", i), 64'(bus.fpu_wb_kind), 64'(vecs[i].e_kind));
      chk($sformatf("v%0d_wb_value", i), 64'(bus.fpu_wb_value), 64'(vecs[i].e_val));
      chk($sformatf("v%0d_ms_valid", i), 64'(bus.memstore_valid), 64'(vecs[i].e_msv));
      chk($sformatf("v%0d_ms_size", i), 64'(bus.memstore_size), 64'(vecs[i].e_size));
      chk($sformatf("v%0d_ms_data", i), bus.memstore_data, vecs[i].e_data);
      tick();
      chk($sformatf("v%0d_done_pulse", i), 64'(bus.fpu_done), 64'd0);
      chk($sformatf("v%0d_wbv_pulse", i), 64'(bus.fpu_wb_valid), 64'd0);
      chk($sformatf("v%0d_msv_pulse", i), 64'(bus.memstore_valid), 64'd0);
      chk($sformatf("v%0d_wb_hold", i), 64'(bus.fpu_wb_value), 64'(vecs[i].e_val));
      chk($sformatf("v%0d_busy_end", i), 64'(bus.fpu_busy), 64'd0);
      chk($sformatf("v%0d_err", i), 64'(bus.err_timeout), 64'd0);
    end

    // DEPTH+1 back-to-back with ex_done held off; issue order across pointer wrap
    for (int k = 0; k < 5; k++) begin
      offer(8'(8'h10 + k), 8'(8'h20 + k), 1'b1, 4'(k), 64'(k));
      #1 chk($sformatf("fill%0d_ready", k), 64'(bus.req_ready), 64'd1);
      if (k == 2) chk("fill_first_issue", 64'(bus.ex_op1), 64'h10);
      tick();
    end
    chk("full_ready", 64'(bus.req_ready), 64'd0);
    chk("full_qcount", 64'(bus.q_count), 64'd4);
    offer(8'hEE, 8'hEE, 1'b0, 4'h0, 64'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("full_hold_qcount", 64'(bus.q_count), 64'd4);
    set_done(1'b1, 1'b1, 3'd2, 16'h0010, 1'b0, 2'd0, 64'h0);
    tick();
    set_done(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 2'd0, 64'h0);
    chk("fill0_done", 64'(bus.fpu_done), 64'd1);
    for (int k = 1; k < 5; k++) begin
      wait_start(6, n);
      chk($sformatf("b2b%0d_gap", k), 64'(n), 64'd1);
      chk($sformatf("b2b%0d_op1", k), 64'(bus.ex_op1), 64'(8'(8'h10 + k)));
      chk($sformatf("b2b%0d_step", k), 64'(bus.ex_step), 64'(k));
      tick();
      set_done(1'b1, 1'b1, 3'd2, 16'(k), 1'b0, 2'd0, 64'h0);
      tick();
      set_done(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 2'd0, 64'h0);
      chk($sformatf("b2b%0d_done", k), 64'(bus.fpu_done), 64'd1);
      chk($sformatf("b2b%0d_wb", k), 64'(bus.fpu_wb_value), 64'(k));
    end
    tick();
    chk("b2b_idle_busy", 64'(bus.fpu_busy), 64'd0);

    // Flush with 3 queued and one in WAIT
    for (int k = 0; k < 4; k++) begin
      offer(8'(8'h30 + k), 8'h00, 1'b0, 4'h0, 64'h0);
      tick();
    end
    bus.req_valid = 1'b0;
    chk("flush_pre_qcount", 64'(bus.q_count), 64'd3);
    bus.flush = 1'b1;
    #1 chk("flush_ready", 64'(bus.req_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    chk("flush_qcount", 64'(bus.q_count), 64'd0);
    chk("flush_busy", 64'(bus.fpu_busy), 64'd1);
    set_done(1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 2'd0, 64'h0);
    tick();
    set_done(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 2'd0, 64'h0);
    chk("flush_inflight_done", 64'(bus.fpu_done), 64'd1);
    chk("flush_inflight_wb", 64'(bus.fpu_wb_value), 64'h1234);
    starts = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.ex_start === 1'b1) starts++;
    end
    chk("flush_no_issue", 64'(starts), 64'd0);
    chk("flush_end_busy", 64'(bus.fpu_busy), 64'd0);

    // Timeout: ex_done never asserted
    offer(8'hD9, 8'hFA, 1'b1, 4'h1, 64'h0);
    tick();
    bus.req_valid = 1'b0;
    wait_start(4, n);
    chk("tmo_start", 64'(bus.ex_start), 64'd1);
    repeat (8) tick();
    chk("tmo_not_yet", 64'(bus.fpu_done), 64'd0);
    chk("tmo_err_pre", 64'(bus.err_timeout), 64'd0);
    tick();
    chk("tmo_done", 64'(bus.fpu_done), 64'd1);
    chk("tmo_wbv", 64'(bus.fpu_wb_valid), 64'd0);
    chk("tmo_msv", 64'(bus.memstore_valid), 64'd0);
    chk("tmo_err", 64'(bus.err_timeout), 64'd1);
    chk("tmo_wb_hold", 64'(bus.fpu_wb_value), 64'h1234);
    repeat (3) tick();
    chk("tmo_err_sticky", 64'(bus.err_timeout), 64'd1);
    chk("tmo_idle_busy", 64'(bus.fpu_busy), 64'd0);

    // Reset mid-WAIT with 2 queued
    for (int k = 0; k < 3; k++) begin
      offer(8'(8'h50 + k), 8'h00, 1'b0, 4'h0, 64'h0);
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    chk("rstw_pre_qcount", 64'(bus.q_count), 64'd2);
    rst = 1'b1;
    #1;
    chk("rstw_qcount", 64'(bus.q_count), 64'd0);
    chk("rstw_busy", 64'(bus.fpu_busy), 64'd0);
    chk("rstw_err", 64'(bus.err_timeout), 64'd0);
    chk("rstw_wb_value", 64'(bus.fpu_wb_value), 64'd0);
    chk("rstw_ms_data", bus.memstore_data, 64'd0);
    chk("rstw_ex_op1", 64'(bus.ex_op1), 64'd0);
    set_done(1'b1, 1'b1, 3'd1, 16'hBEEF, 1'b1, 2'd1, 64'h1);
    tick();
    set_done(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 2'd0, 64'h0);
    rst = 1'b0;
    dones = 0;
    starts = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.fpu_done === 1'b1) dones++;
      if (bus.ex_start === 1'b1) starts++;
    end
    chk("rstw_no_done", 64'(dones), 64'd0);
    chk("rstw_no_start", 64'(starts), 64'd0);
    chk("rstw_ready", 64'(bus.req_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
